complex_divider: RTL

COMPLEX_DIVIDER -- requirements
Module: complex_divider

---
 rtl/complex_divider.sv | 135 +++++++++++++
 1 files changed

// File: rtl/complex_divider.sv
// Signed complex divide (A1+A2i)/(B1+B2i): operands captured on Start, fixed latency of 2*WIDTH+3 edges to DONE.
// Start is ignored while Busy; quotients truncate toward zero and saturate; a zero divisor yields 0 with DivZero.
module complex_divider #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    Start,
  input  logic signed [WIDTH-1:0] A1,
  input  logic signed [WIDTH-1:0] A2,
  input  logic signed [WIDTH-1:0] B1,
  input  logic signed [WIDTH-1:0] B2,
  output logic signed [WIDTH-1:0] Out1,
  output logic signed [WIDTH-1:0] Out2,
  output logic                    Busy,
  output logic                    Done,
  output logic                    DivZero
);

  localparam int PW = 2 * WIDTH;
  localparam int NW = 2 * WIDTH + 1;
  localparam int CW = $clog2(NW);
  localparam logic [NW-1:0] POS_LIM = NW'(2 ** (WIDTH - 1) - 1);
  localparam logic [NW-1:0] NEG_LIM = NW'(2 ** (WIDTH - 1));

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t state, state_nxt;

  logic signed [WIDTH-1:0] a1_q, a2_q, b1_q, b2_q;
  logic [NW-1:0] num_re, num_im, rem_re, rem_im, q_re, q_im, den;
  logic          neg_re, neg_im;
  logic [CW-1:0] cnt;

  logic signed [PW-1:0] p11, p22, p21, p12, sq1, sq2;
  logic signed [NW-1:0] nre, nim, d_s;
  logic [NW-1:0] mag_re, mag_im;
  logic [NW:0]   sh_re, sh_im, diff_re, diff_im;
  logic          ge_re, ge_im;
  logic [NW-1:0] rem_re_n, rem_im_n, q_re_n, q_im_n;

  assign p11 = PW'(a1_q) * PW'(b1_q);
  assign p22 = PW'(a2_q) * PW'(b2_q);
  assign p21 = PW'(a2_q) * PW'(b1_q);
  assign p12 = PW'(a1_q) * PW'(b2_q);
  assign sq1 = PW'(b1_q) * PW'(b1_q);
  assign sq2 = PW'(b2_q) * PW'(b2_q);
  assign nre = NW'(p11) + NW'(p22);
  assign nim = NW'(p21) - NW'(p12);
  assign d_s = NW'(sq1) + NW'(sq2);
  assign mag_re = nre[NW-1] ? -nre : nre;
  assign mag_im = nim[NW-1] ? -nim : nim;

  // One restoring step per cycle for each numerator against the shared divisor
  assign sh_re    = {rem_re, num_re[NW-1]};
  assign sh_im    = {rem_im, num_im[NW-1]};
  assign diff_re  = sh_re - {1'b0, den};
  assign diff_im  = sh_im - {1'b0, den};
  assign ge_re    = (sh_re >= {1'b0, den});
  assign ge_im    = (sh_im >= {1'b0, den});
  assign rem_re_n = ge_re ? diff_re[NW-1:0] : sh_re[NW-1:0];
  assign rem_im_n = ge_im ? diff_im[NW-1:0] : sh_im[NW-1:0];
  assign q_re_n   = {q_re[NW-2:0], ge_re};
  assign q_im_n   = {q_im[NW-2:0], ge_im};

  function automatic logic [WIDTH-1:0] sat(input logic [NW-1:0] mag, input logic neg);
    logic [NW-1:0] t;
    t = -mag;
    if (neg) begin
      if (mag > NEG_LIM) return {1'b1, {(WIDTH-1){1'b0}}};
      return t[WIDTH-1:0];
    end
    if (mag > POS_LIM) return {1'b0, {(WIDTH-1){1'b1}}};
    return mag[WIDTH-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (Start) state_nxt = MUL;
      MUL:     state_nxt = DIV;
      DIV:     if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a1_q <= '0; a2_q <= '0; b1_q <= '0; b2_q <= '0;
      num_re <= '0; num_im <= '0; rem_re <= '0; rem_im <= '0;
      q_re <= '0; q_im <= '0; den <= '0; neg_re <= 1'b0; neg_im <= 1'b0;
      cnt <= '0; Out1 <= '0; Out2 <= '0; DivZero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          a1_q <= A1; a2_q <= A2; b1_q <= B1; b2_q <= B2;
        end
        MUL: begin
          num_re <= mag_re; num_im <= mag_im;
          neg_re <= nre[NW-1]; neg_im <= nim[NW-1];
          den <= d_s;
          rem_re <= '0; rem_im <= '0; q_re <= '0; q_im <= '0;
          cnt <= CW'(NW - 1);
        end
        DIV: begin
          num_re <= num_re << 1; num_im <= num_im << 1;
          rem_re <= rem_re_n; rem_im <= rem_im_n;
          q_re <= q_re_n; q_im <= q_im_n;
          cnt <= cnt - CW'(1);
          if (cnt == '0) begin
            // The quotient bits are meaningless for a zero divisor, so force a clean zero result
            if (den == '0) begin
              Out1 <= '0; Out2 <= '0; DivZero <= 1'b1;
            end else begin
              Out1 <= sat(q_re_n, neg_re);
              Out2 <= sat(q_im_n, neg_im);
              DivZero <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign Busy = (state != IDLE);
  assign Done = (state == DONE);

endmodule
